// File: rtl/countdown_7s_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_7s_if : board-side control/display bundle of the countdown     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface countdown_7s_if;
  logic [7:0] Init;
  logic       Load;
  logic       Start;
  logic       Stop;
  logic [6:0] Msb;
  logic [6:0] Lsb;
  logic       Busy;
  logic       Done;

  modport master (
    output Init, Load, Start, Stop,
    input  Msb, Lsb, Busy, Done
  );

  modport slave (
    input  Init, Load, Start, Stop,
    output Msb, Lsb, Busy, Done
  );
endinterface
`default_nettype wire

// File: rtl/countdown_7s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_7s : two-digit BCD countdown timer (99..00), 7-segment outputs |
// | Optional DONE blink build: define COUNTDOWN_BLINK_EN                     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module countdown_7s #(
  parameter int NBT            = 50000000,
  parameter int CNT_W          = 26,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic          Clk,
  input  logic          Rstn,
  countdown_7s_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(NBT - 1);
  localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

  function automatic logic [3:0] clamp9(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

  // Lit-segment pattern, bit 0 = a .. bit 6 = g.
  function automatic logic [6:0] seg_lit(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  // Button conditioning: two flops for metastability, third for the edge.
  logic [2:0] btn_raw;
  logic [2:0] btn_s1;
  logic [2:0] btn_s2;
  logic [2:0] btn_prev;
  logic [2:0] btn_evt;
  logic       evt_load;
  logic       evt_start;
  logic       evt_stop;

  assign btn_raw   = {bus.Stop, bus.Start, bus.Load};
  assign btn_evt   = btn_s2 & ~btn_prev;
  assign evt_load  = btn_evt[0];
  assign evt_start = btn_evt[1];
  assign evt_stop  = btn_evt[2];

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      btn_s1   <= 3'b000;
      btn_s2   <= 3'b000;
      btn_prev <= 3'b000;
    end else begin
      btn_s1   <= btn_raw;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  state_t           state;
  state_t           state_n;
  logic [3:0]       tens;
  logic [3:0]       units;
  logic [3:0]       tens_n;
  logic [3:0]       units_n;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_n;
  logic             busy;
  logic             done;

  logic [3:0] init_tens;
  logic [3:0] init_units;
  logic [3:0] dec_tens;
  logic [3:0] dec_units;
  logic       count_zero;
  logic       dec_zero;
  logic       presc_run;
  logic       presc_wrap;
  logic       tick;
  logic       start_ok;

  assign init_tens  = clamp9(bus.Init[7:4]);
  assign init_units = clamp9(bus.Init[3:0]);
  assign count_zero = (tens == 4'd0) && (units == 4'd0);
  assign dec_zero   = (dec_tens == 4'd0) && (dec_units == 4'd0);
  assign start_ok   = evt_start && !evt_stop;

  always_comb begin
    dec_tens  = tens;
    dec_units = units - 4'd1;
    if (units == 4'd0) begin
      dec_units = 4'd9;
      dec_tens  = tens - 4'd1;
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  // The blink phase reuses the tick, so the prescaler also runs in DONE.
  assign presc_run = (state == RUN) || (state == DONE);
`else
  assign presc_run = (state == RUN);
`endif
  assign presc_wrap = (presc == PRESC_LAST);
  assign tick       = presc_run && presc_wrap;

  always_comb begin
    state_n = state;
    tens_n  = tens;
    units_n = units;
    presc_n = presc;
    if (presc_run) begin
      presc_n = presc_wrap ? '0 : presc + PRESC_ONE;
    end

    case (state)
      IDLE: begin
        if (evt_load) begin
          tens_n  = init_tens;
          units_n = init_units;
        end else if (start_ok) begin
          state_n = count_zero ? DONE : RUN;
          presc_n = '0;
        end
      end
      RUN: begin
        // A decrement landing in the same cycle as Stop still applies.
        if (tick) begin
          tens_n  = dec_tens;
          units_n = dec_units;
        end
        if (tick && dec_zero) begin
          state_n = DONE;
        end else if (evt_stop) begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (evt_load) begin
          tens_n  = init_tens;
          units_n = init_units;
          presc_n = '0;
          state_n = IDLE;
        end else if (start_ok) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (evt_load) begin
          tens_n  = init_tens;
          units_n = init_units;
          presc_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state <= IDLE;
      tens  <= 4'd0;
      units <= 4'd0;
      presc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      tens  <= tens_n;
      units <= units_n;
      presc <= presc_n;
      busy  <= (state == RUN);
      done  <= (state == DONE);
    end
  end

  logic blank;

`ifdef COUNTDOWN_BLINK_EN
  logic phase;
  logic phase_n;

  // Held at zero outside DONE, so every entry into DONE starts visible.
  always_comb begin
    phase_n = phase;
    if (state != DONE) begin
      phase_n = 1'b0;
    end else if (tick) begin
      phase_n = ~phase;
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      phase <= 1'b0;
    end else begin
      phase <= phase_n;
    end
  end

  assign blank = phase && (state == DONE);
`else
  assign blank = 1'b0;
`endif

  logic [6:0] lit_msb;
  logic [6:0] lit_lsb;

  assign lit_msb = blank ? 7'b0000000 : seg_lit(tens);
  assign lit_lsb = blank ? 7'b0000000 : seg_lit(units);

  assign bus.Msb  = (SEG_ACTIVE_LOW != 0) ? ~lit_msb : lit_msb;
  assign bus.Lsb  = (SEG_ACTIVE_LOW != 0) ? ~lit_lsb : lit_lsb;
  assign bus.Busy = busy;
  assign bus.Done = done;

endmodule
`default_nettype wire
